// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - camera RGB565 byte stream to RGB332 frame-buffer writer
module cam_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_byte_en,
  input  logic [7:0]        cam_data,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic              buf_we,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int COL_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam int BASE_W = ADDR_W + 1;
  localparam logic [COL_W-1:0]  H_MAX  = COL_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] V_MAX  = LINE_W'(V_LINES);
  localparam logic [BASE_W-1:0] H_STEP = BASE_W'(H_PIXELS);

  typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_FRAME, CAPTURE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_vsync_d;
  logic                r_href_d;
  logic                r_phase;
  logic [5:0]          r_hi;
  logic [COL_W-1:0]    r_col;
  logic [LINE_W-1:0]   r_line;
  // Start address of the current line; steps by H_PIXELS, one bit wider so
  // the saturated value H_PIXELS*V_LINES never wraps.
  logic [BASE_W-1:0]   r_base;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_data;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;

  logic w_cap;
  logic w_strobe;
  logic w_vs_rise;
  logic w_href_fall;
  logic w_in_range;

  assign w_cap       = (r_state == CAPTURE);
  assign w_strobe    = w_cap & cam_href & cam_byte_en;
  assign w_vs_rise   = ~r_vsync_d & cam_vsync;
  assign w_href_fall = w_cap & r_href_d & ~cam_href;
  assign w_in_range  = (r_col < H_MAX) && (r_line < V_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: only a clean blank-to-active transition opens a frame
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (start)      w_next = WAIT_VS;
      WAIT_VS:    if (cam_vsync)  w_next = WAIT_FRAME;
      WAIT_FRAME: if (!cam_vsync) w_next = CAPTURE;
      CAPTURE:    if (w_vs_rise)  w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  // Byte pairing, position counters, pixel write port and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
      r_phase   <= 1'b0;
      r_hi      <= '0;
      r_col     <= '0;
      r_line    <= '0;
      r_base    <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_vsync_d <= cam_vsync;
      r_href_d  <= cam_href;
      r_we      <= 1'b0;

      if (r_state == IDLE && start) begin
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
        r_phase <= 1'b0;
        r_col   <= '0;
        r_line  <= '0;
        r_base  <= '0;
      end

      if (w_cap && w_vs_rise) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end

      // A strobe coincident with the closing vsync edge is still written
      if (w_strobe) begin
        if (!r_phase) begin
          r_hi    <= {cam_data[7:5], cam_data[2:0]};
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (w_in_range) begin
            r_we   <= 1'b1;
            r_addr <= ADDR_W'(r_base + BASE_W'(r_col));
            r_data <= {r_hi, cam_data[4:3]};
          end else begin
            r_ovf  <= 1'b1;
          end
          if (r_col < H_MAX) r_col <= r_col + COL_W'(1);
        end
      end else if (w_href_fall) begin
        // Dangling high byte is dropped; empty lines do not advance
        r_phase <= 1'b0;
        r_col   <= '0;
        if (r_col != '0 && r_line < V_MAX) begin
          r_line <= r_line + LINE_W'(1);
          r_base <= r_base + H_STEP;
        end
      end
    end
  end

  assign buf_we   = r_we;
  assign buf_addr = r_addr;
  assign buf_data = r_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - scoreboard bench for cam_capture (H=4, V=2)
module tb_cam_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic          cam_byte_en = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic          buf_we;
  logic          busy;
  logic          done;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  logic [AW+7:0] sb[$];

  int         m_col  = 0;
  int         m_line = 0;
  bit         m_ph   = 0;
  bit         m_cap  = 0;
  bit         m_ovf  = 0;
  logic [7:0] m_hi   = 8'h00;

  cam_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_byte_en(cam_byte_en), .cam_data(cam_data),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every write must match the oldest expected pixel
  initial begin
    logic [AW+7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (buf_we === 1'b1) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_write observed=%0h expected=none", {buf_addr, buf_data});
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("write_addr_data", {20'h0, buf_addr, buf_data}, {20'h0, e});
        end
      end
    end
  end

  task automatic put_byte(input logic [7:0] b);
    logic exp_we;
    exp_we = 1'b0;
    cam_byte_en = 1'b1;
    cam_data = b;
    if (m_cap && cam_href) begin
      if (!m_ph) begin
        m_hi = b;
        m_ph = 1;
      end else begin
        m_ph = 0;
        if (m_col < H && m_line < V) begin
          exp_we = 1'b1;
          sb.push_back({AW'(m_line * H + m_col), m_hi[7:5], m_hi[2:0], b[4:3]});
        end else begin
          m_ovf = 1;
        end
        if (m_col < H) m_col++;
      end
    end
    @(posedge clk);
    #1;
    chk("we_latency", {31'h0, buf_we}, {31'h0, exp_we});
    @(negedge clk);
    cam_byte_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_line();
    cam_href = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_line();
    cam_href = 1'b0;
    if (m_cap) begin
      m_ph = 0;
      if (m_col > 0) m_line++;
      m_col = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    m_col = 0; m_line = 0; m_ph = 0; m_ovf = 0;
    @(posedge clk);
    #1;
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_done", {31'h0, done}, 32'h0);
    chk("start_ovf", {31'h0, ovf}, 32'h0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic frame_open();
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    cam_vsync = 1'b0;
    @(negedge clk);
    m_cap = 1;
  endtask

  task automatic frame_close(input bit exp_ovf);
    cam_vsync = 1'b1;
    m_cap = 0;
    @(posedge clk);
    #1;
    chk("end_done", {31'h0, done}, 32'h1);
    chk("end_busy", {31'h0, busy}, 32'h0);
    chk("end_ovf", {31'h0, ovf}, {31'h0, exp_ovf});
    @(negedge clk);
    cam_href = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"},   {31'h0, buf_we}, 32'h0);
    chk({tag, "_addr"}, {28'h0, buf_addr}, 32'h0);
    chk({tag, "_data"}, {24'h0, buf_data}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_ovf"},  {31'h0, ovf}, 32'h0);
  endtask

  initial begin
    // Reset state
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Two full lines, colour conversion and addresses 0..7
    do_start();
    frame_open();
    begin_line();
    put_byte(8'hF8); put_byte(8'h1F); put_byte(8'h07); put_byte(8'hE0);
    put_byte(8'hA5); put_byte(8'h5A); put_byte(8'h3C); put_byte(8'hC3);
    end_line();
    begin_line();
    for (int i = 0; i < 8; i++) put_byte(8'($urandom_range(0, 255)));
    end_line();
    frame_close(1'b0);
    chk("frame1_drained", sb.size(), 32'h0);

    // Overlong line, odd line, surplus line
    do_start();
    frame_open();
    begin_line();
    for (int i = 0; i < 12; i++) put_byte(8'(8'h11 * (i + 1)));
    end_line();
    chk("ovf_after_long_line", {31'h0, ovf}, 32'h1);
    begin_line();
    put_byte(8'hFF); put_byte(8'h18); put_byte(8'h81); put_byte(8'h08);
    put_byte(8'hEE);
    end_line();
    begin_line();
    put_byte(8'h12); put_byte(8'h34); put_byte(8'h56); put_byte(8'h78);
    end_line();
    frame_close(1'b1);
    chk("frame2_drained", sb.size(), 32'h0);

    // Start mid-frame: nothing until vsync blank ends; second start ignored
    cam_vsync = 1'b0;
    @(negedge clk);
    do_start();
    begin_line();
    put_byte(8'hFF); put_byte(8'hFF);
    end_line();
    frame_open();
    begin_line();
    put_byte(8'hF8); put_byte(8'h1F);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_ignored_busy", {31'h0, busy}, 32'h1);
    put_byte(8'h07);
    // Closing vsync edge lands on the low byte: that pixel is still written
    cam_vsync = 1'b1;
    put_byte(8'hE0);
    m_cap = 0;
    chk("vs_coincident_done", {31'h0, done}, 32'h1);
    chk("vs_coincident_busy", {31'h0, busy}, 32'h0);
    put_byte(8'h55); put_byte(8'hAA);
    end_line();
    chk("frame3_drained", sb.size(), 32'h0);

    // Reset mid-capture after three pixels
    do_start();
    frame_open();
    begin_line();
    for (int i = 0; i < 6; i++) put_byte(8'hFF);
    chk("pre_reset_drained", sb.size(), 32'h0);
    rst = 1'b1;
    m_cap = 0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) put_byte(8'hC6);
    end_line();
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    cam_vsync = 1'b0;
    @(negedge clk);
    begin_line();
    for (int i = 0; i < 4; i++) put_byte(8'h9A);
    end_line();
    chk("idle_after_reset_busy", {31'h0, busy}, 32'h0);
    chk("idle_after_reset_done", {31'h0, done}, 32'h0);
    chk("final_drained", sb.size(), 32'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter H_PIXELS, default 160, pixels stored per line.
REQ-002 Parameter V_LINES, default 120, lines stored per frame.
REQ-003 Parameter ADDR_W, default 15, frame-buffer address width; H_PIXELS*V_LINES SHALL fit in ADDR_W bits.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1, system clock; all logic rising-edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port start, input, 1, one-cycle capture request from the Wishbone camera peripheral.
REQ-008 Port cam_vsync, input, 1, camera frame sync, already synchronised to clk; high = vertical blank.
REQ-009 Port cam_href, input, 1, camera line valid, already synchronised to clk.
REQ-010 Port cam_byte_en, input, 1, one-cycle strobe marking a valid cam_data byte.
REQ-011 Port cam_data, input, 8, camera byte, RGB565, high byte first.
REQ-012 Port buf_addr, output, ADDR_W, frame-buffer write address.
REQ-013 Port buf_data, output, 8, RGB332 pixel.
REQ-014 Port buf_we, output, 1, one-cycle frame-buffer write strobe.
REQ-015 Port busy, output, 1, high from accepted start until frame end.
REQ-016 Port done, output, 1, high from frame end until next accepted start.
REQ-017 Port ovf, output, 1, sticky: line or frame exceeded H_PIXELS/V_LINES.

Function
REQ-018 FSM states: IDLE, WAIT_VS, WAIT_FRAME, CAPTURE.
REQ-019 IDLE: start=1 -> WAIT_VS; next cycle busy=1, done=0, ovf=0, col, line, addr, byte phase cleared.
REQ-020 WAIT_VS: cam_vsync=1 -> WAIT_FRAME (a frame already in progress is never captured).
REQ-021 WAIT_FRAME: cam_vsync=0 -> CAPTURE.
REQ-022 CAPTURE: cam_vsync rising edge (previous 0, current 1) -> IDLE; next cycle busy=0, done=1.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 CAPTURE, cam_href=1, cam_byte_en=1, phase 0: latch cam_data as high byte, phase <= 1.
REQ-025 CAPTURE, cam_href=1, cam_byte_en=1, phase 1: phase <= 0; if col<H_PIXELS and line<V_LINES, assert buf_we next cycle.
REQ-026 Pixel conversion: buf_data = {hi[7:5], hi[2:0], lo[4:3]}; lo = the phase-1 byte.
REQ-027 buf_addr = line*H_PIXELS + col, registered with buf_data; maintained as a running counter, no multiplier.
REQ-028 Pixel write latency: buf_we, buf_addr, buf_data valid exactly 1 cycle after the phase-1 strobe.
REQ-029 col increments on every phase-1 strobe, saturating at H_PIXELS; pixel at col>=H_PIXELS discarded and ovf set.
REQ-030 cam_href falling edge in CAPTURE: col <= 0, phase <= 0, line <= line+1 only if col>0 (empty lines not counted).
REQ-031 Pixels with line>=V_LINES SHALL be discarded and ovf set; addr never exceeds H_PIXELS*V_LINES-1.
REQ-032 cam_byte_en while cam_href=0 or outside CAPTURE SHALL be ignored.
REQ-033 Odd byte count at href fall: dangling high byte discarded, no write.
REQ-034 Vsync rising edge coincident with a phase-1 strobe: pixel still written, then IDLE.
REQ-035 buf_we SHALL never be asserted outside CAPTURE or in the cycle after leaving it, except per REQ-034.

Reset
REQ-036 rst=1 SHALL force, asynchronously: state IDLE, busy=0, done=0, ovf=0, buf_we=0, buf_addr=0, buf_data=0, counters and phase 0.
REQ-037 Reset mid-capture SHALL abort the frame with no further buf_we and require a new start.

Verification
REQ-038 H=4,V=2; start, vsync 1->0, two lines of 8 bytes, vsync rising -> 8 writes, addr 0..7, done=1, busy=0, ovf=0.
REQ-039 Byte pair 0xF8,0x1F -> buf_data 0xE3; pair 0x07,0xE0 -> 0x1C; each 1 cycle after second strobe.
REQ-040 H=4; line of 12 bytes -> writes addr 0..3 only, ovf=1, next line starts at addr 4.
REQ-041 start issued with cam_vsync=0 mid-frame -> no writes until vsync 1->0; second start during busy ignored.
REQ-042 rst pulsed after 3 pixels written -> all outputs 0 that cycle, no further writes, idle until start.
REQ-043 Line of 5 bytes (odd) -> 2 writes, 5th byte dropped; 3 lines when V=2 -> third line dropped, ovf=1.
